// File: rtl/alpha_u_collector.sv
// alpha_u_collector: packs a serial stream of IEEE-754 double alpha words
// into the wide alpha_u frame bus and computes the per-node argmax state
// (x_initial). A complete, well-formed frame is published with a one-cycle
// valid pulse; malformed frames raise a one-cycle frame_error pulse and leave
// the previously published frame untouched.
module alpha_u_collector #(
    parameter  int J       = 14,
    parameter  int A       = 2,
    localparam int J_WIDTH = $clog2(J) + 1,
    localparam int A_WIDTH = $clog2(A) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [J*A*64-1:0]      alpha_u,
    output logic                   alpha_u_tvalid,
    output logic [J*A_WIDTH-1:0]   x_initial,
    output logic                   x_initial_tvalid,
    output logic                   frame_error
);

    localparam int                 NUM_WORDS = J * A;
    localparam int                 K_WIDTH   = $clog2(NUM_WORDS) + 1;
    localparam logic [K_WIDTH-1:0] K_LAST    = K_WIDTH'(NUM_WORDS - 1);
    localparam logic [A_WIDTH-1:0] A_LAST    = A_WIDTH'(A - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EMIT    = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // Maps a double onto an unsigned key whose ordering matches the numeric
    // ordering of the doubles (negatives inverted, positives lifted above).
    function automatic logic [63:0] order_key(input logic [63:0] w);
        logic [63:0] k;
        if (w[63]) begin
            k = ~w;
        end else begin
            k = w | 64'h8000_0000_0000_0000;
        end
        return k;
    endfunction

    state_t                 state_q,      state_d;
    logic [K_WIDTH-1:0]     k_q,          k_d;
    logic [A_WIDTH-1:0]     a_q,          a_d;
    logic [J_WIDTH-1:0]     j_q,          j_d;
    logic [63:0]            max_key_q,    max_key_d;
    logic [A_WIDTH-1:0]     max_idx_q,    max_idx_d;
    logic [J*A*64-1:0]      work_buf_q,   work_buf_d;
    logic [J*A_WIDTH-1:0]   work_x_q,     work_x_d;
    logic [J*A*64-1:0]      alpha_u_q,    alpha_u_d;
    logic [J*A_WIDTH-1:0]   x_initial_q,  x_initial_d;
    logic                   valid_q,      valid_d;
    logic                   frame_err_q,  frame_err_d;
    logic                   tready_q,     tready_d;

    logic                   accept_s;
    logic [63:0]            cand_key_s;
    logic [31:0]            word_lsb_s;
    logic [31:0]            x_lsb_s;

    assign accept_s   = s_axis_tvalid & tready_q;
    assign cand_key_s = order_key(s_axis_tdata);
    assign word_lsb_s = 32'(k_q) << 6;
    assign x_lsb_s    = 32'(j_q) * 32'(A_WIDTH);

    // Next-state, packing, running argmax and publish logic.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        j_d         = j_q;
        max_key_d   = max_key_q;
        max_idx_d   = max_idx_q;
        work_buf_d  = work_buf_q;
        work_x_d    = work_x_q;
        alpha_u_d   = alpha_u_q;
        x_initial_d = x_initial_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (accept_s) begin
                    work_buf_d[word_lsb_s +: 64] = s_axis_tdata;

                    // First state of a node seeds the max; later states only
                    // win when strictly greater, so ties keep the lower index.
                    if ((a_q == {A_WIDTH{1'b0}}) || (cand_key_s > max_key_q)) begin
                        max_key_d = cand_key_s;
                        max_idx_d = a_q;
                    end else begin
                        max_key_d = max_key_q;
                        max_idx_d = max_idx_q;
                    end

                    if (a_q == A_LAST) begin
                        work_x_d[x_lsb_s +: A_WIDTH] = max_idx_d;
                        a_d = {A_WIDTH{1'b0}};
                        j_d = j_q + J_WIDTH'(1);
                    end else begin
                        a_d = a_q + A_WIDTH'(1);
                        j_d = j_q;
                    end
                    k_d = k_q + K_WIDTH'(1);

                    if (k_q == K_LAST) begin
                        k_d = {K_WIDTH{1'b0}};
                        a_d = {A_WIDTH{1'b0}};
                        j_d = {J_WIDTH{1'b0}};
                        if (s_axis_tlast) begin
                            // Publish straight from the updated working
                            // buffers so the pulse lands in the EMIT cycle.
                            alpha_u_d   = work_buf_d;
                            x_initial_d = work_x_d;
                            valid_d     = 1'b1;
                            state_d     = ST_EMIT;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        // Frame ended early: drop everything collected so far.
                        frame_err_d = 1'b1;
                        k_d         = {K_WIDTH{1'b0}};
                        a_d         = {A_WIDTH{1'b0}};
                        j_d         = {J_WIDTH{1'b0}};
                        max_key_d   = 64'h0;
                        max_idx_d   = {A_WIDTH{1'b0}};
                        work_buf_d  = '0;
                        work_x_d    = '0;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_EMIT: begin
                k_d     = {K_WIDTH{1'b0}};
                a_d     = {A_WIDTH{1'b0}};
                j_d     = {J_WIDTH{1'b0}};
                state_d = ST_COLLECT;
            end
            ST_DRAIN: begin
                if (accept_s && s_axis_tlast) begin
                    k_d     = {K_WIDTH{1'b0}};
                    a_d     = {A_WIDTH{1'b0}};
                    j_d     = {J_WIDTH{1'b0}};
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                k_d     = {K_WIDTH{1'b0}};
                a_d     = {A_WIDTH{1'b0}};
                j_d     = {J_WIDTH{1'b0}};
                state_d = ST_COLLECT;
            end
        endcase

        // Ready is registered: it drops only for the single publish cycle.
        tready_d = (state_d != ST_EMIT);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            k_q         <= {K_WIDTH{1'b0}};
            a_q         <= {A_WIDTH{1'b0}};
            j_q         <= {J_WIDTH{1'b0}};
            max_key_q   <= 64'h0;
            max_idx_q   <= {A_WIDTH{1'b0}};
            work_buf_q  <= '0;
            work_x_q    <= '0;
            alpha_u_q   <= '0;
            x_initial_q <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            tready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            j_q         <= j_d;
            max_key_q   <= max_key_d;
            max_idx_q   <= max_idx_d;
            work_buf_q  <= work_buf_d;
            work_x_q    <= work_x_d;
            alpha_u_q   <= alpha_u_d;
            x_initial_q <= x_initial_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            tready_q    <= tready_d;
        end
    end

    assign s_axis_tready    = tready_q;
    assign alpha_u          = alpha_u_q;
    assign alpha_u_tvalid   = valid_q;
    assign x_initial        = x_initial_q;
    assign x_initial_tvalid = valid_q;
    assign frame_error      = frame_err_q;

endmodule
